imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Byte-stream program loader that writes 32-bit instruction words into the pipeline processor's instruction memory.
- Holds the core in reset until the load finishes, then releases it.
- Is the writer/driver for the core and its instruction memory; the processor bench is the reader/observer.
- Sits between a byte source (bench driver or UART receiver) and the instruction-memory write port.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  ADDR_W  instruction-memory word address.
- im_wdata  output  32  instruction word.
- core_rst  output  1  reset to the pipeline core, active high.
- busy  output  1  load in progress.
- done  output  1  level; last load completed.
- err  output  1  sticky; a word index exceeded the memory depth.
- words_loaded  output  16  words consumed in the current or last load.

Behaviour:
- Clocking and reset:
  - One clock domain, clk only.
  - rst is synchronous and active-high.
  - rst is sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, core_rst = 1, all other outputs 0, internal N = 0, byte index = 0.
  - rst asserted mid-load aborts the load and returns to these values on the next edge. Nothing further is written.
- Stream format:
  - Byte 0 = N[7:0], byte 1 = N[15:8].
  - Then N words, each 4 bytes, little-endian: first byte goes to wdata[7:0].
- Byte transfer: a byte is accepted on a rising edge with in_valid && in_ready.
- States:
  - IDLE: in_ready = 0, core_rst = 1. start -> HDR0; also clear words_loaded, err and the address.
  - HDR0: in_ready = 1. On accept, latch N[7:0] -> HDR1.
  - HDR1: in_ready = 1. On accept, latch N[15:8]. If the complete N == 0 -> DONE, else -> DATA.
  - DATA: in_ready = 1. Shift bytes into the assembler; on the 4th accept -> WRITE.
  - WRITE:
    - in_ready = 0; im_we = 1 for exactly this cycle.
    - im_addr = word index[ADDR_W-1:0]; im_wdata = assembled word.
    - Next edge: word index +1, words_loaded +1.
    - If the new words_loaded == N -> DONE, else -> DATA.
  - DONE: core_rst = 0, done = 1, busy = 0. start -> HDR0, with core_rst = 1 and done = 0 from the next cycle.
- Outputs by state:
  - busy = 1 in HDR0, HDR1, DATA, WRITE.
  - core_rst = 1 in every state except DONE.
- Timing:
  - im_we rises the cycle after the 4th byte of a word is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
  - done rises the cycle after the last WRITE, or after HDR1 when N == 0.
- Overflow:
  - A word whose index >= 2**ADDR_W is still consumed and counted.
  - im_we is suppressed for that word and err is set (sticky until the next start or rst).
- Start pulses:
  - start while busy is ignored.
  - start in the same cycle as a byte accept in DONE/IDLE: start wins; no byte is consumed because in_ready = 0.
- Stalls: in_valid low stalls any state indefinitely; no timeout.
- Bytes presented while in_ready = 0 are not consumed; the source holds them.

Decomposition:
- Package loader_pkg:
  - state enum loader_state_t {IDLE, HDR0, HDR1, DATA, WRITE, DONE}.
  - localparams HDR_BYTES = 2, BYTES_PER_WORD = 4.
- Sub-module word_assembler:
  - 2-bit byte counter plus 32-bit little-endian shift/insert register.
  - Outputs word_full when the 4th byte is accepted.
  - Cleared by clr.

Test Plan:
- Reset then idle: hold rst 3 cycles, no start -> core_rst = 1, in_ready = 0, im_we = 0, done = 0 for 20 cycles.
- Two-word load: start; bytes 02 00 | 13 00 50 00 | 93 00 A0 00 ->
  - im_we pulses at addr 0 with 0x00500013, then addr 1 with 0x00A00093.
  - done = 1, core_rst = 0 one cycle after the second write; words_loaded = 2.
- Empty load: start; bytes 00 00 -> no im_we; DONE one cycle after the second header byte; core_rst drops.
- Backpressure and gaps: two-word load with in_valid toggled every other cycle ->
  - Same writes and values as the two-word load.
  - in_ready = 0 exactly in WRITE cycles; no byte lost or duplicated.
- Overflow: ADDR_W = 2, N = 5, words 0x11111111..0x55555555 ->
  - Writes only at addr 0..3.
  - 5th word not written; err = 1; words_loaded = 5; done = 1.
- Reset mid-load: assert rst after 6 bytes of a two-word load ->
  - Next cycle state IDLE, core_rst = 1, no im_we.
  - A new start and full stream then loads correctly from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE
  } loader_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned COUNT_W        = 16;

endpackage

// File: rtl/word_assembler.sv
// Collects BYTES_PER_WORD stream bytes into one little-endian instruction word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt;

  // Bytes enter at the top and shift down, so the first byte ends in word[7:0].
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + CNT_W'(1);
      word <= {byte_in, word[31:8]};
    end
  end

  assign word_full = en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the
// core in reset until the image has been written.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                im_we,
  output logic [ADDR_W-1:0]   im_addr,
  output logic [31:0]         im_wdata,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [COUNT_W-1:0]  words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_t      state, state_nxt;
  logic [COUNT_W-1:0] n_q, n_nxt;
  logic [COUNT_W-1:0] words_nxt;
  logic [COUNT_W-1:0] hdr_n;
  logic               err_nxt;
  logic               in_ready_nxt;
  logic               im_we_nxt;
  logic               busy_nxt;
  logic               core_rst_nxt;
  logic               done_nxt;
  logic               asm_clr;
  logic               accept;
  logic               word_full;
  logic [31:0]        asm_word;

  assign accept = in_valid && in_ready;
  assign hdr_n  = {in_data, n_q[7:0]};

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .en        (accept && (state == DATA)),
    .byte_in   (in_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  // The assembler register is stable through WRITE, so it drives the data bus directly.
  assign im_wdata = asm_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_q          <= '0;
      words_loaded <= '0;
      err          <= 1'b0;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      busy         <= 1'b0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      n_q          <= n_nxt;
      words_loaded <= words_nxt;
      err          <= err_nxt;
      in_ready     <= in_ready_nxt;
      im_we        <= im_we_nxt;
      im_addr      <= ADDR_W'(words_nxt);
      busy         <= busy_nxt;
      core_rst     <= core_rst_nxt;
      done         <= done_nxt;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    words_nxt = words_loaded;
    err_nxt   = err;
    asm_clr   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = HDR0;
          words_nxt = '0;
          err_nxt   = 1'b0;
          asm_clr   = 1'b1;
        end
      end
      HDR0: begin
        if (accept) begin
          n_nxt     = {8'h00, in_data};
          state_nxt = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          n_nxt     = hdr_n;
          state_nxt = (hdr_n == '0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (word_full) state_nxt = WRITE;
      end
      WRITE: begin
        words_nxt = words_loaded + COUNT_W'(1);
        // Out-of-range words are consumed and counted but flagged.
        if (32'(words_loaded) >= DEPTH) err_nxt = 1'b1;
        state_nxt = (words_nxt == n_q) ? DONE : DATA;
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt = (state_nxt == HDR0) || (state_nxt == HDR1) || (state_nxt == DATA);
    busy_nxt     = in_ready_nxt || (state_nxt == WRITE);
    core_rst_nxt = (state_nxt != DONE);
    done_nxt     = (state_nxt == DONE);
    im_we_nxt    = (state_nxt == WRITE) && (32'(words_nxt) < DEPTH);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; two instances (ADDR_W 8 and 2) share one byte stream.
module tb_imem_boot_loader;

  localparam int A_DEPTH = 256;
  localparam int B_DEPTH = 4;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;

  logic        a_in_ready, a_im_we, a_core_rst, a_busy, a_done, a_err;
  logic [7:0]  a_im_addr;
  logic [31:0] a_im_wdata;
  logic [15:0] a_words_loaded;

  logic        b_in_ready, b_im_we, b_core_rst, b_busy, b_done, b_err;
  logic [1:0]  b_im_addr;
  logic [31:0] b_im_wdata;
  logic [15:0] b_words_loaded;

  int total = 0;
  int bad   = 0;

  // Writes observed on each instance's memory port.
  int          a_wr_addr[$];
  logic [31:0] a_wr_data[$];
  int          b_wr_addr[$];

  // Spec-level model state (values expected in the current cycle).
  bit          m_valid = 1'b0;
  bit          m_busy, m_done, m_wc, m_err_a, m_err_b;
  int          m_words, m_widx, m_pos, m_n;
  logic [31:0] m_wword, m_buf;

  imem_boot_loader #(.ADDR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .im_we(a_im_we), .im_addr(a_im_addr), .im_wdata(a_im_wdata),
    .core_rst(a_core_rst), .busy(a_busy), .done(a_done), .err(a_err),
    .words_loaded(a_words_loaded)
  );

  imem_boot_loader #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
    .core_rst(b_core_rst), .busy(b_busy), .done(b_done), .err(b_err),
    .words_loaded(b_words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model, capture writes, then advance the model one cycle.
  always @(negedge clk) begin : cmp
    bit busy_now, wc_now, we_a, we_b;
    int k;
    we_a = m_wc && (m_widx < A_DEPTH);
    we_b = m_wc && (m_widx < B_DEPTH);
    if (m_valid) begin
      check("in_ready_a", 32'(a_in_ready), 32'(m_busy && !m_wc));
      check("in_ready_b", 32'(b_in_ready), 32'(m_busy && !m_wc));
      check("busy_a", 32'(a_busy), 32'(m_busy));
      check("busy_b", 32'(b_busy), 32'(m_busy));
      check("done_a", 32'(a_done), 32'(m_done));
      check("done_b", 32'(b_done), 32'(m_done));
      check("core_rst_a", 32'(a_core_rst), 32'(!m_done));
      check("core_rst_b", 32'(b_core_rst), 32'(!m_done));
      check("words_a", 32'(a_words_loaded), 32'(m_words));
      check("words_b", 32'(b_words_loaded), 32'(m_words));
      check("err_a", 32'(a_err), 32'(m_err_a));
      check("err_b", 32'(b_err), 32'(m_err_b));
      check("we_a", 32'(a_im_we), 32'(we_a));
      check("we_b", 32'(b_im_we), 32'(we_b));
      if (we_a) begin
        check("addr_a", 32'(a_im_addr), 32'(m_widx % A_DEPTH));
        check("wdata_a", a_im_wdata, m_wword);
      end
      if (we_b) begin
        check("addr_b", 32'(b_im_addr), 32'(m_widx % B_DEPTH));
        check("wdata_b", b_im_wdata, m_wword);
      end
    end
    if (a_im_we === 1'b1) begin
      a_wr_addr.push_back(int'(a_im_addr));
      a_wr_data.push_back(a_im_wdata);
    end
    if (b_im_we === 1'b1) b_wr_addr.push_back(int'(b_im_addr));

    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_wc = 1'b0;
      m_err_a = 1'b0; m_err_b = 1'b0; m_words = 0; m_pos = 0; m_n = 0;
      m_widx = 0; m_wword = '0; m_buf = '0;
    end else if (m_valid) begin
      busy_now = m_busy;
      wc_now   = m_wc;
      m_wc     = 1'b0;
      if (wc_now) begin
        if (m_widx >= A_DEPTH) m_err_a = 1'b1;
        if (m_widx >= B_DEPTH) m_err_b = 1'b1;
        m_words++;
        if (m_words == m_n) begin m_busy = 1'b0; m_done = 1'b1; end
      end
      if (start && !busy_now) begin
        m_busy = 1'b1; m_done = 1'b0; m_words = 0; m_err_a = 1'b0; m_err_b = 1'b0;
        m_pos = 0; m_buf = '0;
      end else if (in_valid && busy_now && !wc_now) begin
        if (m_pos == 0) m_n = int'(in_data);
        else if (m_pos == 1) begin
          m_n = m_n + 256 * int'(in_data);
          if (m_n == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end else begin
          k = (m_pos - 2) % 4;
          m_buf[8*k +: 8] = in_data;
          if (k == 3) begin
            m_wc = 1'b1; m_widx = m_words; m_wword = m_buf; m_buf = '0;
          end
        end
        m_pos++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present bytes in order; gaps drops in_valid every other cycle.
  task automatic send(input bq_t bytes, input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  tog = 1'b0;
    bit  acc;
    while (i < bytes.size() && guard < 2000) begin
      in_data  = bytes[i];
      in_valid = gaps ? tog : 1'b1;
      tog      = !tog;
      @(negedge clk);
      acc = in_valid && (a_in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    check("send_all", 32'(i), 32'(bytes.size()));
  endtask

  task automatic wait_done();
    int k = 0;
    while (a_done !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_wait", 32'(a_done), 32'd1);
  endtask

  task automatic clear_caps();
    a_wr_addr.delete();
    a_wr_data.delete();
    b_wr_addr.delete();
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"}, 32'(a_wr_addr.size()), 32'd2);
    if (a_wr_addr.size() == 2) begin
      check({tag, "_addr0"}, 32'(a_wr_addr[0]), 32'd0);
      check({tag, "_data0"}, a_wr_data[0], 32'h0050_0013);
      check({tag, "_addr1"}, 32'(a_wr_addr[1]), 32'd1);
      check({tag, "_data1"}, a_wr_data[1], 32'h00A0_0093);
    end
    check({tag, "_words"}, 32'(a_words_loaded), 32'd2);
    check({tag, "_core_rst"}, 32'(a_core_rst), 32'd0);
  endtask

  initial begin
    bq_t two, empty, ovf, part;
    two   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    empty = '{8'h00, 8'h00};
    part  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
    ovf   = '{8'h05, 8'h00};
    for (int w = 1; w <= 5; w++)
      for (int b = 0; b < 4; b++) ovf.push_back(8'(w * 16'h11));

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    repeat (20) @(posedge clk);
    #1;
    check("idle_core_rst", 32'(a_core_rst), 32'd1);
    check("idle_in_ready", 32'(a_in_ready), 32'd0);
    check("idle_done", 32'(a_done), 32'd0);
    check("idle_we_cnt", 32'(a_wr_addr.size()), 32'd0);

    // Two-word load.
    clear_caps();
    pulse_start();
    send(two, 1'b0);
    wait_done();
    check_two_word("two");

    // Empty load: DONE straight after the header.
    clear_caps();
    pulse_start();
    check("restart_core_rst", 32'(a_core_rst), 32'd1);
    send(empty, 1'b0);
    check("empty_done", 32'(a_done), 32'd1);
    check("empty_core_rst", 32'(a_core_rst), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("empty_nwr", 32'(a_wr_addr.size()), 32'd0);
    check("empty_words", 32'(a_words_loaded), 32'd0);

    // Same load with in_valid toggling.
    clear_caps();
    pulse_start();
    send(two, 1'b1);
    wait_done();
    check_two_word("gap");

    // Overflow: ADDR_W=2 instance drops word 4, ADDR_W=8 instance writes it.
    clear_caps();
    pulse_start();
    send(ovf, 1'b0);
    wait_done();
    check("ovf_nwr_b", 32'(b_wr_addr.size()), 32'd4);
    for (int i = 0; i < b_wr_addr.size(); i++) check("ovf_addr_b", 32'(b_wr_addr[i]), 32'(i));
    check("ovf_err_b", 32'(b_err), 32'd1);
    check("ovf_words_b", 32'(b_words_loaded), 32'd5);
    check("ovf_done_b", 32'(b_done), 32'd1);
    check("ovf_err_a", 32'(a_err), 32'd0);
    check("ovf_nwr_a", 32'(a_wr_addr.size()), 32'd5);
    if (a_wr_addr.size() == 5) check("ovf_data4_a", a_wr_data[4], 32'h5555_5555);

    // Reset after six bytes, then a full reload.
    clear_caps();
    pulse_start();
    send(part, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_core_rst", 32'(a_core_rst), 32'd1);
    check("mid_busy", 32'(a_busy), 32'd0);
    check("mid_we", 32'(a_im_we), 32'd0);
    check("mid_words", 32'(a_words_loaded), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    clear_caps();
    pulse_start();
    send(two, 1'b0);
    wait_done();
    check_two_word("reload");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
